// File: rtl/phi_check.sv
// phi_check: exhaustive truth-table checker for an N-input, single-output DUT.
//
// Sweeps a = 0 .. 2^N-1, holding each vector LAT cycles, then compares the
// sampled dut_z against the truth table captured at start. Reports pass,
// mismatch count and first failing vector at the end of the sweep.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   begin a sweep (sampled in IDLE only)
//   tt        in   [2^N]  expected truth table, bit i = required output for a = i
//   a         out  [N]    stimulus vector to the DUT
//   dut_z     in   DUT response
//   busy      out  high while sweeping
//   done      out  one-cycle end-of-sweep pulse
//   pass      out  last sweep had zero mismatches
//   err_cnt   out  [N+1]  mismatch count
//   first_err out  [N]    index of the first mismatch (0 if none)
//
// Optional feature: define PHI_CHECK_STOP_EN to end the sweep at the first
// mismatch.
module phi_check #(
    parameter int unsigned N   = 3,
    parameter int unsigned LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2**N-1:0] tt,
    output logic [N-1:0]    a,
    input  logic            dut_z,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N:0]      err_cnt,
    output logic [N-1:0]    first_err
);

    localparam int unsigned HoldW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [2**N-1:0]   tt_q, tt_d;
    logic [N-1:0]      a_q, a_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [N:0]        err_q, err_d;
    logic [N-1:0]      first_q, first_d;
    logic              pass_q, pass_d;
    logic              last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tt_q    <= '0;
            a_q     <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            a_q     <= a_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        a_d     = a_q;
        hold_d  = hold_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        last    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tt_d    = tt;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                    a_d     = '0;
                    hold_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (hold_q == HoldLast) begin
                    hold_d = '0;
                    last   = (a_q == {N{1'b1}});
                    if (dut_z != tt_q[a_q]) begin
                        err_d = err_q + (N+1)'(1);
                        if (err_q == '0) first_d = a_q;
`ifdef PHI_CHECK_STOP_EN
                        last = 1'b1;
`endif
                    end
                    // a stays put on the final sample so it names the last vector checked.
                    if (last) begin
                        state_d = StDone;
                        pass_d  = (err_d == '0);
                    end else begin
                        a_d = a_q + N'(1);
                    end
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign a         = a_q;
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign first_err = first_q;

endmodule

// File: tb/tb_phi_check.sv
// Scoreboard bench for phi_check: three instances (N=3/LAT=1, N=3/LAT=3,
// N=8/LAT=1). Stimulus pushes expected end-of-sweep results; per-instance
// monitors pop and compare whenever done is seen.
module tb_phi_check;

    typedef struct {
        int err;
        int first;
        int pass;
        int done_cyc;
        int a;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: N=3, LAT=1, combinational DUT (xor or constant 0)
    logic       start0 = 1'b0;
    logic [7:0] tt0 = '0;
    logic [2:0] a0;
    logic       z0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [2:0] first0;
    int         mode0 = 0;
    always_comb z0 = (mode0 != 0) ? 1'b0 : ^a0;

    // Instance 1: N=3, LAT=3, xor followed by two register stages
    logic       start1 = 1'b0;
    logic [7:0] tt1 = '0;
    logic [2:0] a1;
    logic       z1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] first1;
    logic       r1a = 1'b0, r1b = 1'b0;
    always @(posedge clk) begin
        r1a <= ^a1;
        r1b <= r1a;
    end
    assign z1 = r1b;

    // Instance 2: N=8, LAT=1, constant-0 DUT
    logic         start2 = 1'b0;
    logic [255:0] tt2 = '0;
    logic [7:0]   a2;
    logic         busy2, done2, pass2;
    logic [8:0]   err2;
    logic [7:0]   first2;

    phi_check #(.N(3), .LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .tt(tt0), .a(a0), .dut_z(z0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .first_err(first0)
    );
    phi_check #(.N(3), .LAT(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .tt(tt1), .a(a1), .dut_z(z1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err(first1)
    );
    phi_check #(.N(8), .LAT(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .tt(tt2), .a(a2), .dut_z(1'b0),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err(first2)
    );

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input int err, input int first,
                              input int pass, input int a, input int busy);
        chk({tag, " err_cnt"}, err, e.err);
        chk({tag, " first_err"}, first, e.first);
        chk({tag, " pass"}, pass, e.pass);
        chk({tag, " done cycle"}, cyc, e.done_cyc);
        chk({tag, " a at done"}, a, e.a);
        chk({tag, " busy at done"}, busy, 0);
    endtask

    // Monitors: a done with nothing expected is itself a failure.
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) chk("dut0 unexpected done", 1, 0);
            else check_done("dut0", q0.pop_front(), int'(err0), int'(first0), int'(pass0),
                            int'(a0), int'(busy0));
        end
        if (done1) begin
            if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
            else check_done("dut1", q1.pop_front(), int'(err1), int'(first1), int'(pass1),
                            int'(a1), int'(busy1));
        end
        if (done2) begin
            if (q2.size() == 0) chk("dut2 unexpected done", 1, 0);
            else check_done("dut2", q2.pop_front(), int'(err2), int'(first2), int'(pass2),
                            int'(a2), int'(busy2));
        end
    end

    function automatic int qsize(input int which);
        case (which)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic wait_q(input int which, input int budget);
        int i = 0;
        while (qsize(which) != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk($sformatf("dut%0d sweep completes in budget", which), qsize(which), 0);
        @(negedge clk);
    endtask

    // Pulse start for one cycle; returns k, the cycle count after the accepting edge.
    task automatic pulse(input int which, output int k);
        k = cyc + 1;
        case (which)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        int   k;
        int   i;
        exp_t e;

        repeat (2) @(negedge clk);
        chk("reset dut0 a", int'(a0), 0);
        chk("reset dut0 busy/done/pass", int'({busy0, done0, pass0}), 0);
        chk("reset dut0 err_cnt", int'(err0), 0);
        chk("reset dut0 first_err", int'(first0), 0);
        chk("reset dut2 err_cnt", int'(err2), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: full match, xor DUT
        tt0 = 8'h96; mode0 = 0;
        k = cyc + 1;
        e = '{err: 0, first: 0, pass: 1, done_cyc: k + 8, a: 7};
        q0.push_back(e);
        pulse(0, k);
        wait_q(0, 40);

        // 2: constant-0 DUT; mismatches at a = 1,2,4,7
        mode0 = 1;
        k = cyc + 1;
`ifdef PHI_CHECK_STOP_EN
        e = '{err: 1, first: 1, pass: 0, done_cyc: k + 2, a: 1};
`else
        e = '{err: 4, first: 1, pass: 0, done_cyc: k + 8, a: 7};
`endif
        q0.push_back(e);
        pulse(0, k);
        wait_q(0, 40);
        repeat (3) @(negedge clk);
`ifdef PHI_CHECK_STOP_EN
        chk("retain err_cnt", int'(err0), 1);
`else
        chk("retain err_cnt", int'(err0), 4);
`endif
        chk("retain first_err", int'(first0), 1);
        chk("retain pass", int'(pass0), 0);

        // 3: LAT=3 with a two-stage pipelined xor DUT
        tt1 = 8'h96;
        k = cyc + 1;
        e = '{err: 0, first: 0, pass: 1, done_cyc: k + 24, a: 7};
        q1.push_back(e);
        pulse(1, k);
        wait_q(1, 60);

        // 4: reset mid-sweep; nothing pushed, so any done is flagged
        mode0 = 1;
        pulse(0, k);
        i = 0;
        while (a0 != 3'd4 && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("reached a=4", int'(a0), 4);
        rst = 1'b1;
        #1;
        chk("mid reset a", int'(a0), 0);
        chk("mid reset busy/done/pass", int'({busy0, done0, pass0}), 0);
        chk("mid reset err_cnt", int'(err0), 0);
        chk("mid reset first_err", int'(first0), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        mode0 = 0;
        k = cyc + 1;
        e = '{err: 0, first: 0, pass: 1, done_cyc: k + 8, a: 7};
        q0.push_back(e);
        pulse(0, k);
        wait_q(0, 40);

        // 5: start and tt changes during RUN are ignored
        tt0 = 8'h96; mode0 = 0;
        k = cyc + 1;
        e = '{err: 0, first: 0, pass: 1, done_cyc: k + 8, a: 7};
        q0.push_back(e);
        pulse(0, k);
        repeat (2) @(negedge clk);
        tt0 = 8'hFF;
        pulse(0, i);
        wait_q(0, 40);
        repeat (12) @(negedge clk);

        // 6: N=8, all-ones table vs constant 0
        tt2 = '1;
        k = cyc + 1;
`ifdef PHI_CHECK_STOP_EN
        e = '{err: 1, first: 0, pass: 0, done_cyc: k + 1, a: 0};
`else
        e = '{err: 256, first: 0, pass: 0, done_cyc: k + 256, a: 255};
`endif
        q2.push_back(e);
        pulse(2, k);
        wait_q(2, 400);
        repeat (4) @(negedge clk);

        chk("pending expectations", q0.size() + q1.size() + q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/phi_check.md
# phi_check

Exhaustive truth-table checker for N-input, single-output boolean circuits in the S-box test suite. It generalises the fixed 2- and 3-input function generators to any input width N. It drives every input vector 0..2^N-1 into a device under test (DUT) and compares each sampled DUT response against a captured 2^N-bit expected truth table. At the end of the sweep it reports pass/fail, the mismatch count and the first failing vector.

## Interface
Parameters:
- N, 3: DUT input width; legal 1..8.
- LAT, 1: cycles each vector is held before the DUT output is sampled; legal 1..16. Use 1 for a combinational DUT and k+1 for a DUT with k register stages.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  starts a sweep; sampled only in IDLE.
- tt  in  2^N  expected truth table; bit i is the required DUT output for a = i. Captured when start is accepted.
- a  out  N  stimulus vector to the DUT.
- dut_z  in  1  DUT response.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse marking the end of a sweep.
- pass  out  1  1 when the last sweep had zero mismatches; valid from done onward.
- err_cnt  out  N+1  mismatch count; range 0..2^N, so it cannot overflow.
- first_err  out  N  vector index of the first mismatch; 0 when err_cnt = 0.

## Operation
State machine: IDLE -> RUN -> DONE -> IDLE.
- **IDLE**
  - start = 1 at an edge: capture tt into tt_q.
  - Clear err_cnt, first_err and pass.
  - Set a = 0, clear the hold counter, go to RUN.
- **RUN**
  - Hold a for LAT cycles.
  - On the edge that ends the LAT-th cycle, compare dut_z with tt_q[a].
  - On a mismatch, increment err_cnt. If err_cnt was 0, also load first_err = a.
  - If a = 2^N-1 at that edge, go to DONE and leave a unchanged. Otherwise a <= a+1 and the hold counter restarts.
- **DONE**
  - Lasts one cycle, with done = 1.
  - pass = (err_cnt == 0) is registered on entry to DONE.
  - Go to IDLE on the next edge.
- **Result retention:** err_cnt, first_err and pass hold their values in IDLE until the next accepted start.
- **start while not IDLE:** ignored; a start sampled in RUN or DONE has no effect.
- **tt changes after capture:** no effect on the current sweep.
- **Visibility of err_cnt:** it updates incrementally during RUN, but is final only from the DONE cycle.
- **Reset:** outputs a = 0, busy = 0, done = 0, pass = 0, err_cnt = 0, first_err = 0; state IDLE; tt_q = 0.
  - Reset during RUN aborts the sweep with no done pulse.
  - The first start after reset runs a full clean sweep.

## Timing
- Let start be accepted at edge k.
- Vector i is driven during cycles k+1+i·LAT through k+(i+1)·LAT.
- dut_z for vector i is sampled at edge k+(i+1)·LAT.
- done is high in the cycle after edge k+2^N·LAT. Sweep latency from start to done is 2^N·LAT+1 cycles.
- busy is high from the cycle after edge k through the last RUN cycle, and low in the DONE cycle.
- The earliest next start is accepted one cycle after done, at the IDLE edge.

## Configuration
Macro: PHI_CHECK_STOP_EN.
- **Defined:** the first mismatch ends the sweep. The FSM goes to DONE at the sampling edge, leaving a at the failing vector, with err_cnt = 1, first_err = a and pass = 0. A fully matching sweep behaves exactly as without the macro.
- **Undefined:** every vector is always checked, and err_cnt gives the total number of mismatches.

## Test plan
1. **Full match.** N=3, LAT=1, tt=8'h96, DUT modelled as a[0]^a[1]^a[2]. Start at edge 0 -> a steps 0..7 in cycles 1..8; done at cycle 9; pass=1, err_cnt=0, first_err=0.
2. **Constant-0 DUT.** N=3, LAT=1, tt=8'h96, dut_z=0 -> pass=0, err_cnt=4, first_err=1. Under PHI_CHECK_STOP_EN instead: done at cycle 3, err_cnt=1, first_err=1, a=1.
3. **Multi-cycle latency.** N=3, LAT=3, DUT is the XOR above followed by two register stages -> each vector held 3 cycles; done at cycle 25; pass=1.
4. **Reset mid-sweep.** Assert rst while a=4 -> all outputs 0 immediately, no done pulse. Then start with tt=8'h96 and a correct DUT -> pass=1 after a full 8-vector sweep.
5. **Ignored inputs during RUN.** Pulse start and change tt to 8'hFF during RUN, XOR DUT with tt=8'h96 at start -> single sweep, done once, pass=1.
6. **Maximum width.** N=8, LAT=1, tt=all ones, dut_z=0 -> err_cnt=256 (9'h100) with no overflow; first_err=0; done at cycle 257.
